input_port_buffer: RTL and testbench



---
 rtl/input_port_buffer_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/input_port_buffer.sv | 84 ++++++++
 tb/tb_input_port_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/input_port_buffer_pkg.sv
// Shared router definitions: switch/port encodings, default sizes and the full-threshold helper.
// The almost-full option is selected by defining BUF_ALMOST_FULL_EN at build time.
package input_port_buffer_pkg;

  typedef enum logic [1:0] {
    SW_X1    = 2'd0,
    SW_X2    = 2'd1,
    SW_Y1    = 2'd2,
    SW_LOCAL = 2'd3
  } sw_port_e;

  localparam int unsigned FLIT_W_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT  = 4;
  localparam int unsigned AF_DEFAULT     = 3;

  // Occupancy at which back-pressure is raised.
  function automatic int unsigned full_level(input bit af_en, input int unsigned af_level,
                                             input int unsigned depth);
    return af_en ? af_level : depth;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x FLIT_W register array: synchronous write port, asynchronous read port.
// Contents are not reset; the owning buffer tracks validity through its pointers.
module fifo_mem
  import input_port_buffer_pkg::*;
#(
  parameter int unsigned FLIT_W = FLIT_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [FLIT_W-1:0] rd_data
);

  logic [FLIT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/input_port_buffer.sv
// Router input-port receive buffer: circular FIFO plus registered head-flit output stage.
// Build option BUF_ALMOST_FULL_EN raises `full` early at AF_LEVEL to absorb in-flight flits.
module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int unsigned FLIT_W   = FLIT_W_DEFAULT,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned AF_LEVEL = AF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic                       full,
  input  logic                       rd_en,
  output logic                       empty,
  output logic                       valid,
  output logic [FLIT_W-1:0]          flit_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

`ifdef BUF_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  localparam int unsigned FULL_LEVEL = full_level(AF_EN, AF_LEVEL, DEPTH);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [FLIT_W-1:0] rd_data;
  logic              at_depth;
  logic              pop;
  logic              push;
  logic              drop;

  // Wrap bit makes the pointer difference the true occupancy, including count == DEPTH.
  assign count    = wr_ptr - rd_ptr;
  assign at_depth = (count == PW'(DEPTH));
  assign empty    = (count == '0);
  assign full     = (count >= PW'(FULL_LEVEL));

  assign pop  = rd_en && !empty;
  assign push = wr_en && (!at_depth || pop);
  assign drop = wr_en && at_depth && !pop;

  fifo_mem #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (flit_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      valid    <= 1'b0;
      flit_out <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) overflow <= 1'b1;
      // rd_en while empty retires the presented flit without loading a new one.
      if (rd_en) begin
        valid <= !empty;
        if (pop) flit_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed self-checking bench for input_port_buffer at DEPTH=4, FLIT_W=32, AF_LEVEL=3.
module tb_input_port_buffer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] flit_in;
  logic        full;
  logic        rd_en;
  logic        empty;
  logic        valid;
  logic [31:0] flit_out;
  logic [2:0]  count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  input_port_buffer #(
    .FLIT_W   (32),
    .DEPTH    (4),
    .AF_LEVEL (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .flit_in  (flit_in),
    .full     (full),
    .rd_en    (rd_en),
    .empty    (empty),
    .valid    (valid),
    .flit_out (flit_out),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"},    32'(empty),    32'd1);
    check({tag, "_full"},     32'(full),     32'd0);
    check({tag, "_valid"},    32'(valid),    32'd0);
    check({tag, "_flit_out"}, flit_out,      32'd0);
    check({tag, "_count"},    32'(count),    32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flit_in = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill_1_to_4();
    for (int i = 1; i <= 4; i++) begin
      wr_en   = 1'b1;
      flit_in = 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    // 1: reset values
    do_reset();
    check_reset_vals("rst");

    // 2: single flit, two-cycle latency, retire on empty
    wr_en   = 1'b1;
    flit_in = 32'hA5A5_0001;
    tick();
    wr_en = 1'b0;
    check("single_empty", 32'(empty), 32'd0);
    check("single_count", 32'(count), 32'd1);
    check("single_valid_early", 32'(valid), 32'd0);
    rd_en = 1'b1;
    tick();
    check("single_valid", 32'(valid), 32'd1);
    check("single_flit", flit_out, 32'hA5A5_0001);
    tick();
    check("single_retire", 32'(valid), 32'd0);
    check("single_hold", flit_out, 32'hA5A5_0001);
    rd_en = 1'b0;

    // 3: fill, drop, drain
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      wr_en   = 1'b1;
      flit_in = 32'(i);
      tick();
`ifdef BUF_ALMOST_FULL_EN
      check("fill_full", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
`else
      check("fill_full", 32'(full), (i == 4) ? 32'd1 : 32'd0);
`endif
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd0);
    flit_in = 32'h5;
    tick();
    wr_en = 1'b0;
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd4);
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_flit", flit_out, 32'(i));
      check("drain_valid", 32'(valid), 32'd1);
    end
    tick();
    check("drain_done_valid", 32'(valid), 32'd0);
    check("drain_done_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    rd_en = 1'b0;

    // 4: push and pop together while full
    do_reset();
    fill_1_to_4();
    wr_en   = 1'b1;
    flit_in = 32'h9;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    check("pp_count", 32'(count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_flit1", flit_out, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pp_order", flit_out, (i == 3) ? 32'h9 : 32'(i + 2));
    end
    tick();
    check("pp_end_valid", 32'(valid), 32'd0);
    rd_en = 1'b0;

    // 5: continuous stream across pointer wrap
    do_reset();
    rd_en = 1'b1;
    for (int t = 0; t < 18; t++) begin
      wr_en   = (t < 16);
      flit_in = 32'(t);
      tick();
      check("stream_count_le1", 32'(count <= 3'd1), 32'd1);
      if (t >= 1 && t <= 16) begin
        check("stream_flit", flit_out, 32'(t - 1));
        check("stream_valid", 32'(valid), 32'd1);
      end
    end
    check("stream_ovf", 32'(overflow), 32'd0);
    check("stream_end_valid", 32'(valid), 32'd0);
    check("stream_end_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;
    wr_en = 1'b0;

    // 6: almost-full threshold, then asynchronous reset mid-stream
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      flit_in = 32'(i);
      tick();
`ifdef BUF_ALMOST_FULL_EN
      check("af_full", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
`else
      check("af_full", 32'(full), (i >= 4) ? 32'd1 : 32'd0);
`endif
      check("af_count", 32'(count), (i >= 4) ? 32'd4 : 32'(i));
      check("af_ovf", 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;

    do_reset();
    wr_en   = 1'b1;
    flit_in = 32'h77;
    tick();
    flit_in = 32'h78;
    rd_en   = 1'b1;
    tick();
    check("mid_valid_pre", 32'(valid), 32'd1);
    check("mid_flit_pre", flit_out, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
